mem_port_sched: RTL and testbench
=================================

# mem_port_sched

Scheduler for the single data-memory port shared by the two issue slots of the dual-issue RV32I core. An issued pair may carry a load or store in slot 0, slot 1 or both. The block serializes those accesses in program order (slot 0 before slot 1) onto one request/grant/response memory interface. It stalls the upstream pipeline until the whole pair has finished, then hands each slot's load data to the slot-matched pipeline registers feeding write-back.

## Interface
Parameters:
- none

Ports:
- clk_i  in  1  core clock
- rstn_i  in  1  reset; asynchronous, active-low
- pair_valid_i  in  1  execute stage presents an issued pair
- sN_mem_i  in  1  slot N (N=0,1) is a memory op
- sN_we_i  in  1  slot N is a store
- sN_addr_i  in  32  slot N effective address (from ALU)
- sN_wdata_i  in  32  slot N store data
- sN_be_i  in  4  slot N byte enables
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write enable
- mem_addr_o  out  32  address
- mem_wdata_o  out  32  write data
- mem_be_o  out  4  byte enables
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  response (load data or store ack)
- mem_rdata_i  in  32  load data
- stall_o  out  1  hold fetch/decode/execute
- done_o  out  1  one-cycle pulse: pair complete
- sN_rdata_o  out  32  slot N load result, held until next pair capture

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE (one-hot or encoded; enum in package).
- IDLE, pair_valid_i=1, at least one sN_mem_i=1: capture all slot fields into internal registers. Next state is REQ0 if s0_mem, else REQ1. stall_o=1 this cycle.
- IDLE, pair with no memory op: no capture, stall_o=0, done_o=0, stay IDLE.
- REQN: mem_req_o=1, mem_* driven from captured slot N. On mem_gnt_i go to WAITN; otherwise hold, with all request fields stable.
- WAITN: mem_req_o=0. On mem_rvalid_i:
  - Load: sN_rdata_o <= mem_rdata_i. Store: sN_rdata_o unchanged.
  - From WAIT0: go to REQ1 if captured s1_mem, else DONE. From WAIT1: go to DONE.
- DONE: stall_o=0, done_o=1, go to IDLE.
- stall_o=1 in every state except DONE, and in IDLE when a memory pair is presented. stall_o is combinational in IDLE, Moore elsewhere.
- mem_rvalid_i outside WAITN is ignored. mem_gnt_i outside REQN is ignored.
- At most one outstanding access.
- mem_* outputs are 0 whenever mem_req_o=0.

## Timing
- Reset values: state IDLE; mem_req_o=0; mem_we_o=0; mem_addr_o=0; mem_wdata_o=0; mem_be_o=0; stall_o=0; done_o=0; sN_rdata_o=0; captured fields 0.
- Reset mid-transaction: mem_req_o drops immediately (asynchronous). Any pending response after reset release is ignored.
- Best case (gnt in the REQ cycle, rvalid the cycle after):
  - one memory op: stall_o high 3 cycles (IDLE, REQ, WAIT), DONE on cycle 4;
  - two memory ops: stall_o high 5 cycles.
- Each extra gnt or rvalid wait cycle adds one stall cycle.
- sN_rdata_o is valid from the cycle after its rvalid through done_o, and holds until the next capture.

## Configuration
- MEM_PORT_SCHED_PERF_EN defined: adds ports conflict_cnt_o (32, out) and stall_cnt_o (32, out).
  - conflict_cnt_o increments on each capture with both sN_mem=1.
  - stall_cnt_o increments on every cycle stall_o=1.
  - Both reset to 0 and wrap at 2^32.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared core package holds the state enum mem_sched_state_t and the slot request struct (mem, we, addr, wdata, be).
- One sub-module, mem_slot_capture: the per-slot capture register, instantiated twice.
- FSM and muxing live in the top.

## Test plan
- s0 load only, addr 0x100, gnt immediate, rvalid next with 0xDEADBEEF:
  - mem_req_o 1 cycle with addr 0x100, we 0;
  - s0_rdata_o=0xDEADBEEF;
  - stall_o 3 cycles, done_o at cycle 4.
- s0 store 0x200 data 0x11223344 be 0xF, plus s1 load 0x204 returning 0x55:
  - store issued first, load second;
  - s1_rdata_o=0x55, s0_rdata_o unchanged;
  - stall_o 5 cycles.
- s1-only load with gnt delayed 3 cycles:
  - mem_req_o and addr stable 4 cycles;
  - total stall 6 cycles.
- Pair with no memory op: stall_o stays 0, mem_req_o stays 0, done_o stays 0.
- rstn_i asserted while in WAIT1, with rvalid arriving after release:
  - all outputs return to reset values immediately;
  - the late rvalid leaves sN_rdata_o at 0.
- With MEM_PORT_SCHED_PERF_EN, two dual-memory pairs each with 5 stall cycles: conflict_cnt_o=2, stall_cnt_o=10.

Source files
------------

// File: rtl/mem_port_sched_pkg.sv
// mem_port_sched_pkg
//   Shared types for the dual-issue data-memory port scheduler.
//   - mem_sched_state_t : scheduler FSM states
//   - slot_req_t        : one issue slot's memory request (mem, we, addr, wdata, be)
//   - st_busy()         : true while an access is being requested or awaited
package mem_port_sched_pkg;

    localparam int NUM_SLOTS = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_DONE  = 3'd5
    } mem_sched_state_t;

    typedef struct packed {
        logic        mem;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } slot_req_t;

    function automatic logic st_busy(input mem_sched_state_t s);
        return (s == ST_REQ0) || (s == ST_WAIT0) || (s == ST_REQ1) || (s == ST_WAIT1);
    endfunction

endpackage

// File: rtl/mem_port_sched_if.sv
// mem_port_sched_if
//   Request/grant/response bus between the scheduler and the data memory.
//   master (scheduler): drives mem_req/mem_we/mem_addr/mem_wdata/mem_be,
//                       receives mem_gnt/mem_rvalid/mem_rdata.
//   slave  (memory)   : the mirror image.
interface mem_port_sched_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_sched_slot_capture.sv
// mem_slot_capture
//   Per-slot holding register: latches the slot's request when a pair is
//   accepted and keeps that slot's load result for write-back.
//   i_cap_en : load i_req into o_req
//   i_rd_en  : load i_rdata into o_rdata (load response for this slot)
//   o_req    : captured request
//   o_rdata  : last load result, held until overwritten by a later load
module mem_slot_capture
    import mem_port_sched_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        i_cap_en,
    input  slot_req_t   i_req,
    input  logic        i_rd_en,
    input  logic [31:0] i_rdata,
    output slot_req_t   o_req,
    output logic [31:0] o_rdata
);
    slot_req_t   r_req;
    logic [31:0] r_rdata;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_req   <= '0;
            r_rdata <= '0;
        end else begin
            if (i_cap_en) r_req   <= i_req;
            if (i_rd_en)  r_rdata <= i_rdata;
        end
    end

    assign o_req   = r_req;
    assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_port_sched.sv
// mem_port_sched
//   Serializes the memory ops of an issued dual-issue pair (slot 0 first,
//   then slot 1) onto one request/grant/response port, stalls upstream until
//   the pair has finished and returns per-slot load data.
//   clk_i, rstn_i            : clock, async active-low reset
//   pair_valid_i, sN_*_i     : issued pair from execute
//   mem (master)             : data-memory bus
//   stall_o                  : hold fetch/decode/execute
//   done_o                   : one-cycle pulse when the pair completes
//   sN_rdata_o               : slot N load result
//   Optional MEM_PORT_SCHED_PERF_EN adds conflict_cnt_o / stall_cnt_o.
module mem_port_sched
    import mem_port_sched_pkg::*;
(
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                pair_valid_i,
    input  logic                s0_mem_i,
    input  logic                s0_we_i,
    input  logic [31:0]         s0_addr_i,
    input  logic [31:0]         s0_wdata_i,
    input  logic [3:0]          s0_be_i,
    input  logic                s1_mem_i,
    input  logic                s1_we_i,
    input  logic [31:0]         s1_addr_i,
    input  logic [31:0]         s1_wdata_i,
    input  logic [3:0]          s1_be_i,
    mem_port_sched_if.master    mem,
    output logic                stall_o,
    output logic                done_o,
    output logic [31:0]         s0_rdata_o,
    output logic [31:0]         s1_rdata_o
`ifdef MEM_PORT_SCHED_PERF_EN
    ,
    output logic [31:0]         conflict_cnt_o,
    output logic [31:0]         stall_cnt_o
`endif
);
    mem_sched_state_t    r_state;
    logic                r_done;
    slot_req_t           w_slot_in [NUM_SLOTS];
    slot_req_t           w_cap     [NUM_SLOTS];
    logic [31:0]         w_rdata   [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_rd_en;
    logic                w_capture;
    logic                w_stall;
    slot_req_t           w_bus;

    assign w_slot_in[0] = '{mem: s0_mem_i, we: s0_we_i, addr: s0_addr_i,
                            wdata: s0_wdata_i, be: s0_be_i};
    assign w_slot_in[1] = '{mem: s1_mem_i, we: s1_we_i, addr: s1_addr_i,
                            wdata: s1_wdata_i, be: s1_be_i};

    // A pair is only taken when it actually touches memory.
    assign w_capture = (r_state == ST_IDLE) && pair_valid_i && (s0_mem_i || s1_mem_i);

    // Only loads write back; store acks leave the slot's result untouched.
    assign w_rd_en[0] = (r_state == ST_WAIT0) && mem.mem_rvalid && !w_cap[0].we;
    assign w_rd_en[1] = (r_state == ST_WAIT1) && mem.mem_rvalid && !w_cap[1].we;

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        mem_slot_capture u_cap (
            .clk_i    (clk_i),
            .rstn_i   (rstn_i),
            .i_cap_en (w_capture),
            .i_req    (w_slot_in[k]),
            .i_rd_en  (w_rd_en[k]),
            .i_rdata  (mem.mem_rdata),
            .o_req    (w_cap[k]),
            .o_rdata  (w_rdata[k])
        );
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_capture) r_state <= s0_mem_i ? ST_REQ0 : ST_REQ1;
                end
                ST_REQ0: begin
                    if (mem.mem_gnt) r_state <= ST_WAIT0;
                end
                ST_WAIT0: begin
                    if (mem.mem_rvalid) begin
                        if (w_cap[1].mem) begin
                            r_state <= ST_REQ1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_REQ1: begin
                    if (mem.mem_gnt) r_state <= ST_WAIT1;
                end
                ST_WAIT1: begin
                    if (mem.mem_rvalid) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Bus fields come straight from the captured slot while requesting and
    // are forced to zero otherwise; the async state reset drops them at once.
    always_comb begin
        w_bus = '0;
        case (r_state)
            ST_REQ0: w_bus = w_cap[0];
            ST_REQ1: w_bus = w_cap[1];
            default: w_bus = '0;
        endcase
    end

    assign mem.mem_req   = w_bus.mem;
    assign mem.mem_we    = w_bus.we;
    assign mem.mem_addr  = w_bus.addr;
    assign mem.mem_wdata = w_bus.wdata;
    assign mem.mem_be    = w_bus.be;

    // Combinational in IDLE so the pair is held in the very cycle it arrives.
    assign w_stall    = st_busy(r_state) || w_capture;
    assign stall_o    = w_stall;
    assign done_o     = r_done;
    assign s0_rdata_o = w_rdata[0];
    assign s1_rdata_o = w_rdata[1];

`ifdef MEM_PORT_SCHED_PERF_EN
    logic [31:0] r_conflict_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_conflict_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_capture && s0_mem_i && s1_mem_i) r_conflict_cnt <= r_conflict_cnt + 32'd1;
            if (w_stall)                           r_stall_cnt    <= r_stall_cnt + 32'd1;
        end
    end

    assign conflict_cnt_o = r_conflict_cnt;
    assign stall_cnt_o    = r_stall_cnt;
`endif
endmodule

// File: tb/tb_mem_port_sched.sv
// tb_mem_port_sched
//   Lock-step bench: each pair is expanded into its expected cycle timeline
//   (capture, per-op request/wait phases sized by the chosen grant/response
//   delays, done) and every cycle's outputs are compared against it.
//   Build with MEM_PORT_SCHED_PERF_EN to also cover the counters.
module tb_mem_port_sched;
    import mem_port_sched_pkg::*;

    typedef struct packed {
        logic        stall;
        logic        done;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        pair_valid_i = 1'b0;
    logic        s0_mem_i = 1'b0, s0_we_i = 1'b0, s1_mem_i = 1'b0, s1_we_i = 1'b0;
    logic [31:0] s0_addr_i = '0, s0_wdata_i = '0, s1_addr_i = '0, s1_wdata_i = '0;
    logic [3:0]  s0_be_i = '0, s1_be_i = '0;
    logic        stall_o, done_o;
    logic [31:0] s0_rdata_o, s1_rdata_o;
`ifdef MEM_PORT_SCHED_PERF_EN
    logic [31:0] conflict_cnt_o, stall_cnt_o;
`endif

    mem_port_sched_if u_mem ();

    mem_port_sched dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .pair_valid_i (pair_valid_i),
        .s0_mem_i     (s0_mem_i),
        .s0_we_i      (s0_we_i),
        .s0_addr_i    (s0_addr_i),
        .s0_wdata_i   (s0_wdata_i),
        .s0_be_i      (s0_be_i),
        .s1_mem_i     (s1_mem_i),
        .s1_we_i      (s1_we_i),
        .s1_addr_i    (s1_addr_i),
        .s1_wdata_i   (s1_wdata_i),
        .s1_be_i      (s1_be_i),
        .mem          (u_mem.master),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .s0_rdata_o   (s0_rdata_o),
        .s1_rdata_o   (s1_rdata_o)
`ifdef MEM_PORT_SCHED_PERF_EN
        ,
        .conflict_cnt_o (conflict_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int          n_vec = 0, n_err = 0;
    logic [31:0] exp_rd0 = '0, exp_rd1 = '0, exp_conf = '0, exp_stc = '0;
    int          meas_stall, meas_req, meas_done_at, pair_cyc;
    logic [31:0] meas_first_addr, meas_last_addr;
    slot_req_t   cur_s0, cur_s1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic slot_req_t rnd_slot();
        slot_req_t s;
        s.mem   = rb();
        s.we    = rb();
        s.addr  = $urandom;
        s.wdata = $urandom;
        s.be    = 4'($urandom);
        return s;
    endfunction

    task automatic begin_pair();
        meas_stall = 0; meas_req = 0; meas_done_at = 0; pair_cyc = 0;
        meas_first_addr = '0; meas_last_addr = '0;
    endtask

    // One clock cycle: drive at the falling edge, compare 1 time unit later.
    task automatic cyc(input bit rst, input bit pv, input bit g, input bit rv,
                       input logic [31:0] rd, input exp_t e);
        slot_req_t a, b;
        @(negedge clk_i);
        a = pv ? cur_s0 : rnd_slot();
        b = pv ? cur_s1 : rnd_slot();
        rstn_i       = !rst;
        pair_valid_i = pv;
        {s0_mem_i, s0_we_i, s0_addr_i, s0_wdata_i, s0_be_i} = a;
        {s1_mem_i, s1_we_i, s1_addr_i, s1_wdata_i, s1_be_i} = b;
        u_mem.mem_gnt    = g;
        u_mem.mem_rvalid = rv;
        u_mem.mem_rdata  = rd;
        #1;
        pair_cyc++;
        if (stall_o) meas_stall++;
        if (u_mem.mem_req) begin
            if (meas_req == 0) meas_first_addr = u_mem.mem_addr;
            meas_last_addr = u_mem.mem_addr;
            meas_req++;
        end
        if (done_o) meas_done_at = pair_cyc;
        chk("stall_o",     32'(stall_o),         32'(e.stall));
        chk("done_o",      32'(done_o),          32'(e.done));
        chk("mem_req",     32'(u_mem.mem_req),   32'(e.req));
        chk("mem_we",      32'(u_mem.mem_we),    32'(e.we));
        chk("mem_addr",    u_mem.mem_addr,       e.addr);
        chk("mem_wdata",   u_mem.mem_wdata,      e.wdata);
        chk("mem_be",      32'(u_mem.mem_be),    32'(e.be));
        chk("s0_rdata",    s0_rdata_o,           exp_rd0);
        chk("s1_rdata",    s1_rdata_o,           exp_rd1);
`ifdef MEM_PORT_SCHED_PERF_EN
        chk("conflict_cnt", conflict_cnt_o,      exp_conf);
        chk("stall_cnt",    stall_cnt_o,         exp_stc);
`endif
        if (e.stall) exp_stc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, rb(), rb(), $urandom, '0);
    endtask

    // Request phase of g+1 cycles then wait phase of r+1 cycles for one slot.
    task automatic op(input int k, input slot_req_t sl, input int g, input int r,
                      input logic [31:0] d);
        exp_t e;
        for (int i = 0; i <= g; i++) begin
            e = '0; e.stall = 1'b1; e.req = 1'b1; e.we = sl.we;
            e.addr = sl.addr; e.wdata = sl.wdata; e.be = sl.be;
            cyc(0, 1, (i == g), rb(), $urandom, e);
        end
        for (int i = 0; i <= r; i++) begin
            e = '0; e.stall = 1'b1;
            cyc(0, 1, rb(), (i == r), (i == r) ? d : $urandom, e);
        end
        if (!sl.we) begin
            if (k == 0) exp_rd0 = d;
            else        exp_rd1 = d;
        end
    endtask

    task automatic capture_cycle();
        exp_t e;
        e = '0; e.stall = cur_s0.mem | cur_s1.mem;
        cyc(0, 1, rb(), rb(), $urandom, e);
        if (cur_s0.mem && cur_s1.mem) exp_conf++;
    endtask

    task automatic run_pair(input slot_req_t s0, input slot_req_t s1,
                            input int g0, input int r0, input int g1, input int r1,
                            input logic [31:0] d0, input logic [31:0] d1);
        exp_t e;
        cur_s0 = s0; cur_s1 = s1;
        begin_pair();
        capture_cycle();
        if (!(s0.mem || s1.mem)) return;
        if (s0.mem) op(0, s0, g0, r0, d0);
        if (s1.mem) op(1, s1, g1, r1, d1);
        e = '0; e.done = 1'b1;
        cyc(0, 1, rb(), rb(), $urandom, e);
    endtask

    function automatic slot_req_t mk(input bit m, input bit w, input logic [31:0] a,
                                     input logic [31:0] wd, input logic [3:0] be);
        slot_req_t s;
        s.mem = m; s.we = w; s.addr = a; s.wdata = wd; s.be = be;
        return s;
    endfunction

    initial begin
        exp_t e;
        slot_req_t none;
        none = '0;
        u_mem.mem_gnt = 1'b0; u_mem.mem_rvalid = 1'b0; u_mem.mem_rdata = '0;

        // Reset state
        begin_pair();
        cyc(1, 0, 0, 0, '0, '0);
        cyc(1, 0, 1, 1, 32'h1234_5678, '0);
        idle(2);

        // s0 load only, best case
        run_pair(mk(1, 0, 32'h100, 32'h0, 4'hF), none, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0);
        chk("t1_stall_cycles", 32'(meas_stall), 32'd3);
        chk("t1_req_cycles",   32'(meas_req),   32'd1);
        chk("t1_req_addr",     meas_first_addr, 32'h100);
        chk("t1_done_cycle",   32'(meas_done_at), 32'd4);
        chk("t1_s0_rdata",     s0_rdata_o,      32'hDEAD_BEEF);
        idle(2);

        // s0 store then s1 load
        run_pair(mk(1, 1, 32'h200, 32'h1122_3344, 4'hF), mk(1, 0, 32'h204, 32'h0, 4'hF),
                 0, 0, 0, 0, 32'hFFFF_0000, 32'h55);
        chk("t2_stall_cycles", 32'(meas_stall),  32'd5);
        chk("t2_req_cycles",   32'(meas_req),    32'd2);
        chk("t2_first_addr",   meas_first_addr,  32'h200);
        chk("t2_second_addr",  meas_last_addr,   32'h204);
        chk("t2_s1_rdata",     s1_rdata_o,       32'h55);
        chk("t2_s0_rdata",     s0_rdata_o,       32'hDEAD_BEEF);
        idle(1);

        // s1-only load with grant delayed 3 cycles
        run_pair(none, mk(1, 0, 32'h300, 32'h0, 4'h3), 0, 0, 3, 0, 32'h0, 32'h77);
        chk("t3_stall_cycles", 32'(meas_stall), 32'd6);
        chk("t3_req_cycles",   32'(meas_req),   32'd4);
        chk("t3_s1_rdata",     s1_rdata_o,      32'h77);
        idle(1);

        // Pair with no memory op
        run_pair(mk(0, 1, 32'h400, 32'h9, 4'hF), mk(0, 0, 32'h404, 32'h8, 4'hF),
                 0, 0, 0, 0, 32'h0, 32'h0);
        chk("t4_stall_cycles", 32'(meas_stall),   32'd0);
        chk("t4_req_cycles",   32'(meas_req),     32'd0);
        chk("t4_done_seen",    32'(meas_done_at), 32'd0);
        idle(1);

        // Randomized pairs with random grant/response delays
        for (int n = 0; n < 150; n++) begin
            run_pair(rnd_slot(), rnd_slot(),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom, $urandom);
            idle($urandom_range(0, 2));
        end

        // Reset while waiting on slot 1's response; response arrives late
        cur_s0 = mk(1, 0, 32'h500, 32'h0, 4'hF);
        cur_s1 = mk(1, 0, 32'h504, 32'h0, 4'hF);
        begin_pair();
        capture_cycle();
        op(0, cur_s0, 0, 0, 32'hA5A5_0001);
        e = '0; e.stall = 1'b1; e.req = 1'b1; e.addr = 32'h504; e.be = 4'hF;
        cyc(0, 1, 1, 0, $urandom, e);
        e = '0; e.stall = 1'b1;
        cyc(0, 1, 0, 0, $urandom, e);
        exp_rd0 = '0; exp_rd1 = '0; exp_conf = '0; exp_stc = '0;
        cyc(1, 0, 0, 0, '0, '0);
        cyc(0, 0, 0, 1, 32'hCAFE_F00D, '0);
        idle(3);
        chk("rst_s0_rdata", s0_rdata_o, 32'h0);
        chk("rst_s1_rdata", s1_rdata_o, 32'h0);
        chk("rst_mem_req",  32'(u_mem.mem_req), 32'd0);

        // Two best-case dual-memory pairs after reset
        run_pair(mk(1, 1, 32'h600, 32'h1, 4'hF), mk(1, 0, 32'h604, 32'h0, 4'hF),
                 0, 0, 0, 0, 32'h0, 32'h61);
        run_pair(mk(1, 0, 32'h700, 32'h0, 4'hF), mk(1, 1, 32'h704, 32'h2, 4'hC),
                 0, 0, 0, 0, 32'h71, 32'h0);
`ifdef MEM_PORT_SCHED_PERF_EN
        chk("perf_conflict_cnt", conflict_cnt_o, 32'd2);
        chk("perf_stall_cnt",    stall_cnt_o,    32'd10);
`endif
        chk("p_s0_rdata", s0_rdata_o, 32'h71);
        chk("p_s1_rdata", s1_rdata_o, 32'h61);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
